// File: rtl/joy_db15_splitter_emu.sv
`default_nettype none
// ============================================================================
// Module  : joy_db15_splitter_emu
// Brief   : Emulates a DB15 two-player splitter: serialises both joysticks
//           onto joy_data under host joy_load / joy_clk control.
// Config  : JOY_DB15_EMU_SYNC_EN - 2-flop synchronisers on host strobes.
// Rev     : 1.0 - initial release
// ============================================================================
module joy_db15_splitter_emu #(
  parameter int LEAD_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int         c_SR_W         = LEAD_BITS + 24;
  localparam logic [4:0] c_IDX_FULL     = 5'(LEAD_BITS + 24);
  localparam logic [4:0] c_IDX_PRE_LAST = 5'(LEAD_BITS + 22);

  logic              r_clk_s;
  logic              r_clk_d;
  logic              r_load_s;
  logic              w_rise;
  logic [23:0]       w_buttons;
  logic [c_SR_W-1:0] w_snap;
  logic [c_SR_W-1:0] r_sr;
  logic [4:0]        r_idx;
  logic              r_frame_done;
  logic [7:0]        r_frame_cnt;
  logic              w_unused_bits;

`ifdef JOY_DB15_EMU_SYNC_EN
  logic r_clk_m;
  logic r_load_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_m  <= 1'b1;
      r_clk_s  <= 1'b1;
      r_load_m <= 1'b1;
      r_load_s <= 1'b1;
    end else begin
      r_clk_m  <= joy_clk;
      r_clk_s  <= r_clk_m;
      r_load_m <= joy_load;
      r_load_s <= r_load_m;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s  <= 1'b1;
      r_load_s <= 1'b1;
    end else begin
      r_clk_s  <= joy_clk;
      r_load_s <= joy_load;
    end
  end
`endif

  // Resetting the edge flop high keeps a low joy_clk at release from looking like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_d <= 1'b1;
    end else begin
      r_clk_d <= r_clk_s;
    end
  end

  assign w_rise = r_clk_s & ~r_clk_d;

  // Bit k of w_buttons is the k-th button on the wire (k = 0 leaves first).
  assign w_buttons = {
    joystick2[4],  joystick2[5],  joystick2[6],  joystick2[7],
    joystick2[10], joystick2[11], joystick2[8],  joystick2[9],
    joystick1[10], joystick1[11], joystick1[8],  joystick1[9],
    joystick2[3],  joystick2[2],  joystick2[1],  joystick2[0],
    joystick1[3],  joystick1[2],  joystick1[1],  joystick1[0],
    joystick1[4],  joystick1[5],  joystick1[6],  joystick1[7]
  };

  assign w_unused_bits = &{1'b0, joystick1[15:12], joystick2[15:12]};

  generate
    if (LEAD_BITS > 0) begin : g_lead
      assign w_snap = {~w_buttons, {LEAD_BITS{1'b1}}};
    end else begin : g_no_lead
      assign w_snap = ~w_buttons;
    end
  endgenerate

  // Load wins over a coincident shift strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '1;
      r_idx <= '0;
    end else if (!r_load_s) begin
      r_sr  <= w_snap;
      r_idx <= '0;
    end else if (w_rise) begin
      r_sr <= {1'b1, r_sr[c_SR_W-1:1]};
      if (r_idx != c_IDX_FULL) begin
        r_idx <= r_idx + 5'd1;
      end
    end
  end

  // The shift leaving index at LEAD_BITS+22 is the one that presents P2 A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_load_s && w_rise && (r_idx == c_IDX_PRE_LAST)) begin
        r_frame_done <= 1'b1;
        r_frame_cnt  <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign joy_data   = r_sr[0];
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_splitter_emu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_joy_db15_splitter_emu
// Brief   : Scoreboard bench: stimulus queues expected values, monitor checks.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_joy_db15_splitter_emu;

    localparam int c_K_DATA   = 0;
    localparam int c_K_CNT    = 1;
    localparam int c_K_PULSES = 2;
    localparam int c_K_AT     = 3;
    localparam int c_K_DONE   = 4;

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_data;
    logic [15:0] joystick1 = 16'h0000;
    logic [15:0] joystick2 = 16'h0000;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    host_shifts = 0;
    int    done_pulses = 0;
    int    pulse_at = -1;
    int    exp_cnt = 0;
    int    exp_done = 0;

    joy_db15_splitter_emu #(.LEAD_BITS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) begin
                done_pulses++;
                pulse_at = host_shifts;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                item_t it;
                int    act;
                it = sb.pop_front();
                case (it.kind)
                    c_K_DATA:   act = int'(joy_data);
                    c_K_CNT:    act = int'(frame_cnt);
                    c_K_PULSES: act = done_pulses;
                    c_K_AT:     act = pulse_at;
                    default:    act = int'(frame_done);
                endcase
                n_checks++;
                if (act == it.exp) n_pass++;
                else $display("FAIL %s: got %0d expected %0d", it.name, act, it.exp);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input int exp, input string name);
        item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic frame(input logic [15:0] j1, input logic [15:0] j2,
                         input logic [23:0] mask, input int nsh, input int half,
                         input bit chk, input int chg_at, input logic [15:0] j1_new,
                         input bit glitch);
        joystick1 = j1;
        joystick2 = j2;
        joy_load = 1'b0;
        host_shifts = 0;
        if (glitch) begin
            tick(half);
            joy_clk = 1'b1;
            tick(half);
            joy_clk = 1'b0;
        end
        tick(half);
        if (chk) expect_val(c_K_DATA, 1, "lead_bit_in_load");
        joy_load = 1'b1;
        tick(half);
        for (int s = 1; s <= nsh; s++) begin
            joy_clk = 1'b1;
            host_shifts++;
            tick(half);
            if (chk) begin
                if (s <= 24) expect_val(c_K_DATA, mask[s-1] ? 0 : 1, $sformatf("bit%0d", s));
                else expect_val(c_K_DATA, 1, $sformatf("bit%0d", s));
            end
            if (s == chg_at) joystick1 = j1_new;
            joy_clk = 1'b0;
            tick(half);
        end
    endtask

    task automatic check_frame_end(input string tag, input bit full);
        tick(2);
        expect_val(c_K_CNT, exp_cnt, {tag, "_cnt"});
        expect_val(c_K_PULSES, exp_done, {tag, "_pulses"});
        if (full) expect_val(c_K_AT, 24, {tag, "_pulse_slot"});
        expect_val(c_K_DONE, 0, {tag, "_done_low"});
        tick(1);
    endtask

    initial begin
        // Reset state
        tick(3);
        expect_val(c_K_DATA, 1, "rst_data");
        expect_val(c_K_DONE, 0, "rst_done");
        expect_val(c_K_CNT, 0, "rst_cnt");
        n_checks++;
        if (joy_data === 1'b1) n_pass++;
        else $display("FAIL rst_data_direct: got %b expected 1", joy_data);
        n_checks++;
        if (frame_done === 1'b0) n_pass++;
        else $display("FAIL rst_done_direct: got %b expected 0", frame_done);
        n_checks++;
        if (frame_cnt === 8'd0) n_pass++;
        else $display("FAIL rst_cnt_direct: got %0d expected 0", frame_cnt);
        tick(1);
        reset = 1'b0;
        tick(2);
        for (int s = 0; s < 2; s++) begin
            joy_clk = 1'b1; tick(6);
            expect_val(c_K_DATA, 1, "post_rst_no_load");
            joy_clk = 1'b0; tick(6);
        end

        // No buttons, 26-clock frame
        frame(16'h0000, 16'h0000, 24'h000000, 26, 6, 1, 0, 16'h0, 0);
        exp_cnt++; exp_done++;
        check_frame_end("idle", 1);

        // P1 A alone -> wire slot 4 after lead bit
        frame(16'h0010, 16'h0000, 24'h000008, 25, 6, 1, 0, 16'h0, 0);
        exp_cnt++; exp_done++;
        check_frame_end("p1_a", 1);

        // P2 Sel, Start, R
        frame(16'h0000, 16'h0C01, 24'h0C0100, 26, 6, 1, 0, 16'h0, 0);
        exp_cnt++; exp_done++;
        check_frame_end("p2_sel_start_r", 1);

        // Everything pressed on both sticks
        frame(16'h0FFF, 16'h0FFF, 24'hFFFFFF, 26, 6, 1, 0, 16'h0, 0);
        exp_cnt++; exp_done++;
        check_frame_end("all_pressed", 1);

        // P1 F,R and P2 D,Down
        frame(16'h0201, 16'h0084, 24'h101410, 26, 6, 1, 0, 16'h0, 0);
        exp_cnt++; exp_done++;
        check_frame_end("mixed", 1);

        // Snapshot frozen: P1 changes after shift 3
        frame(16'h0000, 16'h0000, 24'h000000, 26, 6, 1, 3, 16'h0FFF, 0);
        exp_cnt++; exp_done++;
        check_frame_end("frozen", 1);

        // Abort after 10 shifts
        frame(16'h0010, 16'h0000, 24'h000008, 10, 6, 1, 0, 16'h0, 0);
        check_frame_end("abort", 0);

        // Restart with a joy_clk edge during load; P1 D in first button slot
        frame(16'h0080, 16'h0000, 24'h000001, 26, 6, 1, 0, 16'h0, 1);
        exp_cnt++; exp_done++;
        check_frame_end("restart", 1);

        // Reset asserted mid-frame, checked before the next clk edge
        frame(16'h0FFF, 16'h0000, 24'h00F0FF, 3, 6, 1, 0, 16'h0, 0);
        reset = 1'b1;
        expect_val(c_K_DATA, 1, "midrst_data");
        expect_val(c_K_CNT, 0, "midrst_cnt");
        tick(1);
        n_checks++;
        if (joy_data === 1'b1) n_pass++;
        else $display("FAIL midrst_data_direct: got %b expected 1", joy_data);
        n_checks++;
        if (frame_cnt === 8'd0) n_pass++;
        else $display("FAIL midrst_cnt_direct: got %0d expected 0", frame_cnt);
        tick(1);
        reset = 1'b0;
        exp_cnt = 0;
        tick(2);
        for (int s = 0; s < 2; s++) begin
            joy_clk = 1'b1; tick(6);
            expect_val(c_K_DATA, 1, "midrst_released_no_load");
            joy_clk = 1'b0; tick(6);
        end

        // Counter wrap: 255 frames, then one more
        for (int f = 0; f < 255; f++) begin
            frame(16'h0010, 16'h0000, 24'h000008, 24, 4, 0, 0, 16'h0, 0);
        end
        exp_cnt = 255; exp_done += 255;
        check_frame_end("preset255", 1);
        frame(16'h0000, 16'h0000, 24'h000000, 24, 4, 1, 0, 16'h0, 0);
        exp_cnt = 0; exp_done++;
        check_frame_end("wrap", 1);

        tick(3);
        n_checks++;
        if (frame_cnt === 8'd0) n_pass++;
        else $display("FAIL wrap_cnt_direct: got %0d expected 0", frame_cnt);
        n_checks++;
        if (done_pulses == exp_done) n_pass++;
        else $display("FAIL pulses_direct: got %0d expected %0d", done_pulses, exp_done);
        if (n_pass == n_checks) $display("PASS all checks");
        else $display("FAIL summary: got %0d expected %0d", n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
